pipe_hazard_ctrl: RTL and testbench

- Sequencing controller for the decode-to-execute pipeline register in the 4-stage 8-bit pipeline (8 registers, 3-bit register numbers, dual write-back destinations).
- Generates the hold enable and bubble-insert control for that register, and stalls decode while a multi-cycle ALU op occupies EX.
- Produces registered operand-forwarding selects aligned with the operands entering EX.
- Handles branch flush, which aborts a multi-cycle op and clears pipeline control.

---
 rtl/pipe_hazard_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control for the decode-to-execute register: multi-cycle stall,
// bubble insert, branch flush and registered forwarding selects. Optional HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MC_LAT = 3,
  parameter int unsigned CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_valid,
  input  logic       dec_multicycle,
  input  logic [2:0] dec_rs1,
  input  logic [2:0] dec_rs2,
  input  logic       ex_regwrite,
  input  logic [2:0] ex_reg,
  input  logic [2:0] ex_reg2,
  input  logic       wb_regwrite,
  input  logic [2:0] wb_reg,
  input  logic       flush,
  output logic       stall,
  output logic       id_ex_en,
  output logic       id_ex_bubble,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       mc_active,
  output logic       mc_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] perf_stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_IDLE = '0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  // MC_LAT==1 loads zero, so single-cycle builds never leave IDLE
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 1);

  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic [1:0]       fwd_a_nxt;
  logic [1:0]       fwd_b_nxt;

  function automatic logic [1:0] fwd_pick(input logic [2:0] rs, input logic exw,
                                          input logic [2:0] e1, input logic [2:0] e2,
                                          input logic wbw, input logic [2:0] wr);
    logic [1:0] sel;
    sel = 2'b00;
    if (exw && rs == e1)      sel = 2'b01;
    else if (exw && rs == e2) sel = 2'b10;
    else if (wbw && rs == wr) sel = 2'b11;
    return sel;
  endfunction

  always_comb begin
    stall        = (cnt != CNT_IDLE);
    mc_active    = stall;
    id_ex_en     = ~stall | flush;
    id_ex_bubble = flush | (~stall & ~dec_valid);
    accept       = dec_valid & ~stall & ~flush;
    fwd_a_nxt    = fwd_pick(dec_rs1, ex_regwrite, ex_reg, ex_reg2, wb_regwrite, wb_reg);
    fwd_b_nxt    = fwd_pick(dec_rs2, ex_regwrite, ex_reg, ex_reg2, wb_regwrite, wb_reg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= CNT_IDLE;
      mc_done <= 1'b0;
    end else begin
      mc_done <= ~flush & (cnt == CNT_LAST);
      if (flush)
        cnt <= CNT_IDLE;
      else if (stall)
        cnt <= cnt - CNT_LAST;
      else if (accept && dec_multicycle)
        cnt <= CNT_LOAD;
    end
  end

  // Bubble (including flush) clears the selects; a held register keeps them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
    end else if (id_ex_bubble) begin
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
    end else if (id_ex_en) begin
      fwd_a_sel <= fwd_a_nxt;
      fwd_b_sel <= fwd_b_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_stall_cnt <= '0;
    else if (stall && perf_stall_cnt != '1)
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int unsigned LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dec_valid = 1'b0, dec_multicycle = 1'b0;
  logic [2:0] dec_rs1 = '0, dec_rs2 = '0;
  logic ex_regwrite = 1'b0, wb_regwrite = 1'b0;
  logic [2:0] ex_reg = '0, ex_reg2 = '0, wb_reg = '0;
  logic flush = 1'b0;
  logic stall, id_ex_en, id_ex_bubble, mc_active, mc_done;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [15:0] perf_val;

  pipe_hazard_ctrl #(.MC_LAT(LAT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_multicycle(dec_multicycle),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .ex_regwrite(ex_regwrite), .ex_reg(ex_reg),
    .ex_reg2(ex_reg2), .wb_regwrite(wb_regwrite), .wb_reg(wb_reg), .flush(flush),
    .stall(stall), .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mc_active(mc_active), .mc_done(mc_done)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(perf_val)
`endif
  );
`ifndef HAZARD_PERF_CNT_EN
  assign perf_val = '0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic stall, en, bubble, done;
    logic [1:0] fa, fb;
    logic [15:0] perf;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  // Model: cycles of stall still owed, selects of the instruction now in EX,
  // pending completion pulse, stall-cycle tally.
  int m_owed = 0;
  logic [1:0] m_fa = '0, m_fb = '0;
  logic m_done = 1'b0;
  int m_perf = 0;

  function automatic logic [1:0] src_of(input logic [2:0] rs, input logic exw,
                                        input logic [2:0] e1, input logic [2:0] e2,
                                        input logic wbw, input logic [2:0] wr);
    logic en[3];
    logic [2:0] rg[3];
    en[0] = exw; en[1] = exw; en[2] = wbw;
    rg[0] = e1;  rg[1] = e2;  rg[2] = wr;
    for (int i = 0; i < 3; i++)
      if (en[i] && rg[i] == rs) return 2'(i + 1);
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare against the oldest prediction
  always @(negedge clk) begin
    #2;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("stall", 16'(stall), 16'(e.stall));
      check("mc_active", 16'(mc_active), 16'(e.stall));
      check("id_ex_en", 16'(id_ex_en), 16'(e.en));
      check("id_ex_bubble", 16'(id_ex_bubble), 16'(e.bubble));
      check("mc_done", 16'(mc_done), 16'(e.done));
      check("fwd_a_sel", 16'(fwd_a_sel), 16'(e.fa));
      check("fwd_b_sel", 16'(fwd_b_sel), 16'(e.fb));
`ifdef HAZARD_PERF_CNT_EN
      check("perf_stall_cnt", perf_val, e.perf);
`endif
    end
  end

  task automatic push_expect(input logic v, input logic fl);
    exp_t e;
    e.stall  = (m_owed > 0);
    e.en     = !e.stall || fl;
    e.bubble = fl || (!e.stall && !v);
    e.done   = m_done;
    e.fa     = m_fa;
    e.fb     = m_fb;
    e.perf   = 16'(m_perf);
    sb.push_back(e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; dec_valid = 1'b0; dec_multicycle = 1'b0; flush = 1'b0;
      m_owed = 0; m_fa = '0; m_fb = '0; m_done = 1'b0; m_perf = 0;
      push_expect(1'b0, 1'b0);
    end
  endtask

  task automatic cycle(input logic v, input logic mc, input logic [2:0] r1, input logic [2:0] r2,
                       input logic exw, input logic [2:0] e1, input logic [2:0] e2,
                       input logic wbw, input logic [2:0] wr, input logic fl);
    logic busy;
    @(negedge clk);
    rst = 1'b0;
    dec_valid = v; dec_multicycle = mc; dec_rs1 = r1; dec_rs2 = r2;
    ex_regwrite = exw; ex_reg = e1; ex_reg2 = e2; wb_regwrite = wbw; wb_reg = wr; flush = fl;
    push_expect(v, fl);
    busy = (m_owed > 0);
    if (busy && m_perf < 65535) m_perf++;
    m_done = (m_owed == 1) && !fl;
    if (fl) begin
      m_owed = 0; m_fa = '0; m_fb = '0;
    end else if (busy) begin
      m_owed--;
    end else if (v) begin
      m_fa = src_of(r1, exw, e1, e2, wbw, wr);
      m_fb = src_of(r2, exw, e1, e2, wbw, wr);
      if (mc) m_owed = LAT - 1;
    end else begin
      m_fa = '0; m_fb = '0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(2);
    // single-cycle ops
    for (int i = 0; i < 4; i++) cycle(1, 0, 3'(i), 3'(i + 1), 0, 0, 0, 0, 0, 0);
    // multi-cycle op with decode held behind it, then a following op
    cycle(1, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 2, 0, 0, 0, 0, 0, 0);
    // flush in first busy cycle
    cycle(1, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 2, 0, 0, 0, 0, 0, 1);
    idle(3);
    // forwarding priority
    cycle(1, 0, 3, 5, 1, 3, 5, 1, 3, 0);
    cycle(1, 0, 3, 5, 0, 3, 5, 1, 3, 0);
    cycle(1, 0, 0, 7, 1, 0, 0, 1, 7, 0);
    idle(2);
    // reset while cnt==1
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset(2);
    idle(3);
    // back-to-back multi-cycle ops from a fresh stall tally
    do_reset(1);
    for (int i = 0; i < 6; i++) cycle(1, 1, 2, 4, 1, 2, 6, 1, 4, 0);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset(1);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4,
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
            $urandom_range(0, 11) == 0);
    end
    idle(2);
    @(negedge clk);
    #4;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
